// File: rtl/debug_sequencer_pkg.sv
// Shared definitions for debug_sequencer: FSM state encodings, host command bytes
// and the dump-order section codes (STEP encoding is only reachable with DEBUG_STEP_EN).
package debug_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_RUN       = 4'd2,
    ST_STEP      = 4'd3,
    ST_DUMP_SEL  = 4'd4,
    ST_DUMP_SEND = 4'd5,
    ST_DUMP_WAIT = 4'd6
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h64;  // 'd'
  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'

  typedef enum logic [1:0] {
    SEC_PC    = 2'd0,
    SEC_CYCLE = 2'd1,
    SEC_REG   = 2'd2,
    SEC_MEM   = 2'd3
  } section_e;

  // Maps a dump word index onto the section it belongs to.
  function automatic section_e dump_section(input int idx, input int n_regs);
    section_e sec;
    if (idx == 32'sd0) begin
      sec = SEC_PC;
    end else if (idx == 32'sd1) begin
      sec = SEC_CYCLE;
    end else if (idx < (32'sd2 + n_regs)) begin
      sec = SEC_REG;
    end else begin
      sec = SEC_MEM;
    end
    return sec;
  endfunction

endpackage

// File: rtl/debug_sequencer_word_serializer.sv
// word_serializer: holds one NBITS word and presents it DATA_BITS at a time,
// MSB byte first, advancing each time the transmitter acknowledges a byte.
module word_serializer #(
  parameter int NBITS     = 32,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [NBITS-1:0]     i_word,
  input  logic                 i_next,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_last
);

  localparam int BYTES = NBITS / DATA_BITS;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [NBITS-1:0] shift_r;
  logic [BC_W-1:0]  cnt_r;

  // Word capture and per-byte shift towards the MSB.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (i_load) begin
      shift_r <= i_word;
      cnt_r   <= '0;
    end else if (i_next) begin
      shift_r <= shift_r << DATA_BITS;
      cnt_r   <= cnt_r + BC_W'(1);
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  assign o_byte = shift_r[NBITS-1 -: DATA_BITS];
  assign o_last = (cnt_r == BC_W'(BYTES - 1));

endmodule

// File: rtl/debug_sequencer.sv
// debug_sequencer: UART command decoder, instruction loader, run/step clock gate and
// post-run state dumper. Define DEBUG_STEP_EN to build the single-step 's' command.
module debug_sequencer
  import debug_sequencer_pkg::*;
#(
  parameter int               NBITS       = 32,
  parameter int               DATA_BITS   = 8,
  parameter int               N_REGS      = 32,
  parameter int               N_MEM       = 16,
  parameter int               INSTR_DEPTH = 256,
  parameter logic [NBITS-1:0] HALT_WORD   = {NBITS{1'b1}}
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_rx_ready,
  input  logic [DATA_BITS-1:0]           i_rx_data,
  input  logic                           i_tx_done,
  input  logic                           i_halt,
  input  logic [NBITS-1:0]               i_pc,
  input  logic [NBITS-1:0]               i_cycle_count,
  input  logic [NBITS-1:0]               i_reg_data,
  input  logic [NBITS-1:0]               i_mem_data,
  output logic [DATA_BITS-1:0]           o_tx_data,
  output logic                           o_tx_start,
  output logic                           o_run,
  output logic [$clog2(N_REGS)-1:0]      o_reg_sel,
  output logic [NBITS-1:0]               o_mem_sel,
  output logic [$clog2(INSTR_DEPTH)-1:0] o_ins_addr,
  output logic [NBITS-1:0]               o_ins_data,
  output logic                           o_ins_we,
  output logic [3:0]                     o_state
);

  localparam int BYTES       = NBITS / DATA_BITS;
  localparam int BC_W        = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int AW          = $clog2(INSTR_DEPTH);
  localparam int REG_W       = $clog2(N_REGS);
  localparam int TOTAL_WORDS = 2 + N_REGS + N_MEM;
  localparam int IDX_W       = $clog2(TOTAL_WORDS);

  state_e               state_r;
  logic                 rx_ready_q_r;
  logic [BC_W-1:0]      byte_cnt_r;
  logic [NBITS-1:0]     load_word_r;
  logic [AW-1:0]        wr_addr_r;
  logic [AW-1:0]        ins_addr_r;
  logic [NBITS-1:0]     ins_data_r;
  logic                 ins_we_r;
  logic                 run_r;
  logic                 tx_start_r;
  logic [DATA_BITS-1:0] tx_data_r;
  logic [REG_W-1:0]     reg_sel_r;
  logic [NBITS-1:0]     mem_sel_r;
  logic [IDX_W-1:0]     dump_idx_r;
  logic                 sel_wait_r;

  logic                 rx_take_s;
  logic [NBITS-1:0]     next_word_s;
  section_e             section_s;
  logic [NBITS-1:0]     cap_word_s;
  logic [IDX_W-1:0]     reg_off_s;
  logic [IDX_W-1:0]     mem_off_s;
  logic                 tx_ack_s;
  logic                 ser_load_s;
  logic                 ser_next_s;
  logic [DATA_BITS-1:0] ser_byte_s;
  logic                 ser_last_s;

  // A held-high rx_ready level counts as a single byte.
  assign rx_take_s   = i_rx_ready & ~rx_ready_q_r;
  assign next_word_s = (load_word_r << DATA_BITS) | NBITS'(i_rx_data);
  assign section_s   = dump_section(32'(dump_idx_r), N_REGS);
  assign reg_off_s   = dump_idx_r - IDX_W'(2);
  assign mem_off_s   = dump_idx_r - IDX_W'(2 + N_REGS);
  // A done pulse that coincides with our own start pulse belongs to the previous byte.
  assign tx_ack_s    = (state_r == ST_DUMP_WAIT) & i_tx_done & ~tx_start_r;
  assign ser_load_s  = (state_r == ST_DUMP_SEL) & sel_wait_r;
  assign ser_next_s  = tx_ack_s & ~ser_last_s;

  // Selects the source of the dump word being captured this cycle.
  always_comb begin
    cap_word_s = i_pc;
    case (section_s)
      SEC_PC:    cap_word_s = i_pc;
      SEC_CYCLE: cap_word_s = i_cycle_count;
      SEC_REG:   cap_word_s = i_reg_data;
      SEC_MEM:   cap_word_s = i_mem_data;
      default:   cap_word_s = i_pc;
    endcase
  end

  word_serializer #(
    .NBITS     (NBITS),
    .DATA_BITS (DATA_BITS)
  ) u_word_serializer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (ser_load_s),
    .i_word  (cap_word_s),
    .i_next  (ser_next_s),
    .o_byte  (ser_byte_s),
    .o_last  (ser_last_s)
  );

  // Main sequencer FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r      <= ST_IDLE;
      rx_ready_q_r <= 1'b0;
      byte_cnt_r   <= '0;
      load_word_r  <= '0;
      wr_addr_r    <= '0;
      ins_addr_r   <= '0;
      ins_data_r   <= '0;
      ins_we_r     <= 1'b0;
      run_r        <= 1'b0;
      tx_start_r   <= 1'b0;
      tx_data_r    <= '0;
      reg_sel_r    <= '0;
      mem_sel_r    <= '0;
      dump_idx_r   <= '0;
      sel_wait_r   <= 1'b0;
    end else begin
      rx_ready_q_r <= i_rx_ready;
      ins_we_r     <= 1'b0;
      tx_start_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          run_r      <= 1'b0;
          byte_cnt_r <= '0;
          dump_idx_r <= '0;
          sel_wait_r <= 1'b0;
          if (rx_take_s) begin
            if (i_rx_data == DATA_BITS'(CMD_LOAD)) begin
              state_r   <= ST_LOAD;
              wr_addr_r <= '0;
            end else if (i_rx_data == DATA_BITS'(CMD_RUN)) begin
              state_r <= ST_RUN;
`ifdef DEBUG_STEP_EN
            end else if (i_rx_data == DATA_BITS'(CMD_STEP)) begin
              state_r <= ST_STEP;
              run_r   <= 1'b1;
`endif
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_LOAD: begin
          if (rx_take_s) begin
            load_word_r <= next_word_s;
            if (byte_cnt_r == BC_W'(BYTES - 1)) begin
              byte_cnt_r <= '0;
              ins_we_r   <= 1'b1;
              ins_addr_r <= wr_addr_r;
              ins_data_r <= next_word_s;
              wr_addr_r  <= wr_addr_r + AW'(1);
              if ((next_word_s == HALT_WORD) || (wr_addr_r == AW'(INSTR_DEPTH - 1))) begin
                state_r <= ST_IDLE;
              end
            end else begin
              byte_cnt_r <= byte_cnt_r + BC_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (i_halt) begin
            run_r   <= 1'b0;
            state_r <= ST_DUMP_SEL;
          end else begin
            run_r <= 1'b1;
          end
        end
        ST_STEP: begin
          // run_r was raised on entry, so this state lasts exactly one enabled cycle.
          run_r <= 1'b0;
`ifdef DEBUG_STEP_EN
          state_r <= ST_DUMP_SEL;
`else
          state_r <= ST_IDLE;
`endif
        end
        ST_DUMP_SEL: begin
          run_r <= 1'b0;
          if (!sel_wait_r) begin
            sel_wait_r <= 1'b1;
            case (section_s)
              SEC_REG: reg_sel_r <= REG_W'(reg_off_s);
              SEC_MEM: mem_sel_r <= NBITS'(mem_off_s);
              default: begin
                reg_sel_r <= reg_sel_r;
                mem_sel_r <= mem_sel_r;
              end
            endcase
          end else begin
            sel_wait_r <= 1'b0;
            state_r    <= ST_DUMP_SEND;
          end
        end
        ST_DUMP_SEND: begin
          tx_start_r <= 1'b1;
          tx_data_r  <= ser_byte_s;
          state_r    <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          if (tx_ack_s) begin
            if (!ser_last_s) begin
              state_r <= ST_DUMP_SEND;
            end else if (dump_idx_r == IDX_W'(TOTAL_WORDS - 1)) begin
              state_r <= ST_IDLE;
            end else begin
              dump_idx_r <= dump_idx_r + IDX_W'(1);
              state_r    <= ST_DUMP_SEL;
            end
          end
        end
        default: begin
          run_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_data  = tx_data_r;
  assign o_tx_start = tx_start_r;
  assign o_run      = run_r;
  assign o_reg_sel  = reg_sel_r;
  assign o_mem_sel  = mem_sel_r;
  assign o_ins_addr = ins_addr_r;
  assign o_ins_data = ins_data_r;
  assign o_ins_we   = ins_we_r;
  assign o_state    = state_r;

endmodule

// File: tb/tb_debug_sequencer.sv
// Scoreboard bench for debug_sequencer: expected tx bytes and instruction writes are
// queued when stimulus is issued; a monitor process pops and compares on each DUT event.
module tb_debug_sequencer;

  logic        i_clk         = 1'b0;
  logic        i_reset       = 1'b1;
  logic        i_rx_ready    = 1'b0;
  logic [7:0]  i_rx_data     = 8'h00;
  logic        i_tx_done     = 1'b0;
  logic        i_halt        = 1'b0;
  logic [31:0] i_pc          = 32'h0;
  logic [31:0] i_cycle_count = 32'h0;
  logic [31:0] i_reg_data;
  logic [31:0] i_mem_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_run;
  logic [4:0]  o_reg_sel;
  logic [31:0] o_mem_sel;
  logic [7:0]  o_ins_addr;
  logic [31:0] o_ins_data;
  logic        o_ins_we;
  logic [3:0]  o_state;

  int tests = 0;
  int fails = 0;
  int run_cycles = 0;
  int tx_count = 0;
  logic [7:0]  tx_q[$];
  logic [39:0] ins_q[$];

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] reg_val(input logic [4:0] i);
    return {3'b101, i, 8'h5A, 3'b011, i, 3'b000, i};
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {4'h8, a[3:0], 8'hE7, 4'h1, a[3:0], 4'hF, ~a[3:0]} ^ {31'd0, |a[31:4]};
  endfunction

  assign i_reg_data = reg_val(o_reg_sel);
  assign i_mem_data = mem_val(o_mem_sel);

  debug_sequencer dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_ready    (i_rx_ready),
    .i_rx_data     (i_rx_data),
    .i_tx_done     (i_tx_done),
    .i_halt        (i_halt),
    .i_pc          (i_pc),
    .i_cycle_count (i_cycle_count),
    .i_reg_data    (i_reg_data),
    .i_mem_data    (i_mem_data),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .o_run         (o_run),
    .o_reg_sel     (o_reg_sel),
    .o_mem_sel     (o_mem_sel),
    .o_ins_addr    (o_ins_addr),
    .o_ins_data    (o_ins_data),
    .o_ins_we      (o_ins_we),
    .o_state       (o_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) tx_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_dump();
    push_word(i_pc);
    push_word(i_cycle_count);
    for (int r = 0; r < 32; r++) push_word(reg_val(r[4:0]));
    for (int m = 0; m < 16; m++) push_word(mem_val(m));
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_ready = 1'b1;
    repeat (hold) @(negedge i_clk);
    i_rx_ready = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string name);
    int n = 0;
    while (o_state !== st && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check(name, o_state, st);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a write.
  initial forever begin
    @(negedge i_clk);
    if (o_tx_start) begin
      tx_count++;
      if (tx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: actual byte %02h required no byte", o_tx_data);
      end else begin
        check("tx_byte", o_tx_data, tx_q.pop_front());
      end
    end
    if (o_ins_we) begin
      if (ins_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ins_unexpected: actual %02h:%08h required no write", o_ins_addr, o_ins_data);
      end else begin
        check("ins_write", {o_ins_addr, o_ins_data}, ins_q.pop_front());
      end
    end
    if (o_run) run_cycles++;
  end

  // Transmitter model: acknowledges each started byte a few cycles later.
  initial forever begin
    @(negedge i_clk);
    if (o_tx_start) begin
      repeat (2) @(negedge i_clk);
      i_tx_done = 1'b1;
      @(negedge i_clk);
      i_tx_done = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int tx_snap;

    // Reset held two cycles
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    check("reset_state", o_state, 4'd0);
    check("reset_run_tx", {o_run, o_tx_start, o_ins_we}, 3'b000);
    check("reset_data", {o_tx_data, o_ins_addr, o_ins_data}, 48'h0);
    check("reset_sel", {o_reg_sel, o_mem_sel}, 37'h0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Program load: two words, second is the halt word
    ins_q.push_back({8'd0, 32'h0022_2020});
    ins_q.push_back({8'd1, 32'hFFFF_FFFF});
    send_byte(8'h64, 1);
    check("load_entry", o_state, 4'd1);
    send_byte(8'h00, 1);
    send_byte(8'h22, 1);
    send_byte(8'h20, 1);
    send_byte(8'h20, 1);
    for (int k = 0; k < 4; k++) send_byte(8'hFF, 1);
    wait_state(4'd0, 20, "load_end_idle");
    check("load_writes_left", ins_q.size(), 0);

    // Held-high rx_ready delivers a single byte
    ins_q.push_back({8'd0, 32'h1234_5678});
    ins_q.push_back({8'd1, 32'hFFFF_FFFF});
    send_byte(8'h64, 1);
    send_byte(8'h12, 5);
    send_byte(8'h34, 1);
    send_byte(8'h56, 1);
    send_byte(8'h78, 1);
    for (int k = 0; k < 4; k++) send_byte(8'hFF, 1);
    wait_state(4'd0, 20, "held_end_idle");
    check("held_writes_left", ins_q.size(), 0);

    // Continuous run for ten cycles, then full dump
    i_pc = 32'h0040_01AC;
    i_cycle_count = 32'h0000_0B0A;
    push_dump();
    run_cycles = 0;
    tx_count = 0;
    send_byte(8'h63, 1);
    n = 0;
    while (run_cycles < 10 && n < 200) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    i_halt = 1'b1;
    @(negedge i_clk);
    check("run_dump_state", o_state, 4'd4);
    wait_state(4'd0, 3000, "run_dump_done");
    check("run_cycles", run_cycles, 10);
    check("run_dump_len", tx_count, 200);
    check("run_dump_left", tx_q.size(), 0);
    i_halt = 1'b0;

    // Single step
    i_cycle_count = 32'h0000_0001;
    run_cycles = 0;
    tx_count = 0;
`ifdef DEBUG_STEP_EN
    push_dump();
    send_byte(8'h73, 1);
    wait_state(4'd0, 3000, "step_dump_done");
    check("step_run_cycles", run_cycles, 1);
    check("step_dump_len", tx_count, 200);
    check("step_dump_left", tx_q.size(), 0);
`else
    send_byte(8'h73, 1);
    check("step_ignored_state", o_state, 4'd0);
    repeat (5) @(negedge i_clk);
    check("step_ignored_run", run_cycles, 0);
    check("step_ignored_tx", tx_count, 0);
`endif

    // Halt already high on entry, then reset in the middle of the dump
    i_halt = 1'b1;
    i_pc = 32'hDEAD_0004;
    push_dump();
    run_cycles = 0;
    tx_count = 0;
    send_byte(8'h63, 1);
    n = 0;
    while (tx_count < 7 && n < 500) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check("middump_reached", tx_count, 7);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("middump_state", o_state, 4'd0);
    check("middump_outputs", {o_run, o_tx_start}, 2'b00);
    i_reset = 1'b0;
    tx_q.delete();
    tx_snap = tx_count;
    repeat (50) @(negedge i_clk);
    check("middump_no_more_tx", tx_count, tx_snap);
    check("halt_entry_no_run", run_cycles, 0);
    i_halt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
